// File: rtl/tt_strobed_delay_line.sv
// Multi-bit delay line that shifts once per divider tick, with a registered
// tap selector and a flag that goes high once every stage holds real data.
module tt_strobed_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 100,
  parameter int unsigned DIV_W = 4,
  parameter int unsigned TAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] din,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_last,
  output logic             tick,
  output logic             primed
);

  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [DIV_W-1:0]  cnt;
  logic [FILL_W-1:0] fill;
  logic [WIDTH-1:0]  stage [DEPTH];
  logic [WIDTH-1:0]  tap_c;

  // Gated by rst_n so no strobe escapes while reset is held.
  assign tick = rst_n & ena & ~clear & (cnt == '0);

  // Down-counting divider; div is only sampled at reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= div;
    end else if (ena) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  // Saturating count of ticks since reset/clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (tick && (fill != FILL_W'(DEPTH))) begin
      fill <= fill + FILL_W'(1);
    end
  end

  // Stage shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (clear) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (tick) begin
      stage[0] <= din;
      for (int unsigned k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  // Tap mux; out-of-range selections fall through to zero.
  always_comb begin
    tap_c = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (tap_sel == TAP_W'(k)) tap_c = stage[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else begin
      dout <= tap_c;
    end
  end

  assign dout_last = stage[DEPTH-1];
  assign primed    = (fill == FILL_W'(DEPTH));

endmodule

// File: tb/tb_tt_strobed_delay_line.sv
// Directed bench for tt_strobed_delay_line: a vector table for short
// divider/tap/clear interplay plus hand sequences for the long-running cases.
module tb_tt_strobed_delay_line;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 100;
  localparam int unsigned DIV_W = 4;
  localparam int unsigned TAP_W = 8;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             clear;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] din;
  logic [TAP_W-1:0] tap_sel;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dout_last;
  logic             tick;
  logic             primed;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       ena;
    logic       clear;
    logic [7:0] din;
    logic [7:0] tap;
    logic       exp_tick;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl [15];

  tt_strobed_delay_line #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W), .TAP_W(TAP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .div(div),
    .din(din), .tap_sel(tap_sel), .dout(dout), .dout_last(dout_last),
    .tick(tick), .primed(primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic exp_t;
    // Vectors with div=2, starting just after two flushing clear cycles.
    tbl[0]  = '{1'b1, 1'b0, 8'hA1, 8'd0, 1'b1, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'hB2, 8'd0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 8'hC3, 8'd0, 1'b0, 8'hA1};
    tbl[3]  = '{1'b1, 1'b0, 8'hD4, 8'd0, 1'b1, 8'hA1};
    tbl[4]  = '{1'b0, 1'b0, 8'hE5, 8'd1, 1'b0, 8'hA1};
    tbl[5]  = '{1'b0, 1'b0, 8'hE5, 8'd0, 1'b0, 8'hA1};
    tbl[6]  = '{1'b1, 1'b0, 8'hE5, 8'd0, 1'b0, 8'hD4};
    tbl[7]  = '{1'b1, 1'b0, 8'hE5, 8'd2, 1'b0, 8'hD4};
    tbl[8]  = '{1'b1, 1'b1, 8'hF6, 8'd1, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 8'hF6, 8'd1, 1'b0, 8'hA1};
    tbl[10] = '{1'b1, 1'b0, 8'h77, 8'd1, 1'b1, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 8'h88, 8'd0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b1, 8'h99, 8'd0, 1'b0, 8'h77};
    tbl[13] = '{1'b0, 1'b0, 8'h99, 8'd0, 1'b0, 8'h77};
    tbl[14] = '{1'b1, 1'b0, 8'hAA, 8'd0, 1'b1, 8'h00};

    // Reset with hostile inputs
    rst_n = 1'b1; ena = 1'b1; clear = 1'b0; div = '0; din = 8'hFF; tap_sel = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dout_last", 32'(dout_last), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_primed", 32'(primed), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_dout", 32'(dout), 32'h0);

    // Divider: div=14 then 2; ticks at 0,15,30,33,36,39
    din = 8'h00;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) rst_n = 1'b1;
      div = (c >= 16) ? DIV_W'(2) : DIV_W'(14);
      #1;
      exp_t = (c == 0) || (c == 15) || (c == 30) || (c == 33) || (c == 36) || (c == 39);
      chk($sformatf("div_tick_c%0d", c), 32'(tick), 32'(exp_t));
    end

    // Two flushing clears, then the vector table
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear = 1'b1; ena = 1'b1; div = DIV_W'(2);
      #1 chk("flush_tick", 32'(tick), 32'h0);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ena = tbl[i].ena; clear = tbl[i].clear; din = tbl[i].din; tap_sel = tbl[i].tap;
      #1;
      chk($sformatf("tbl%0d_tick", i), 32'(tick), 32'(tbl[i].exp_tick));
      chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_primed", i), 32'(primed), 32'h0);
    end

    // Stream din=j every clock, tap 5
    @(negedge clk);
    clear = 1'b1; ena = 1'b1; div = '0; tap_sel = 8'd5;
    for (int j = 0; j < 120; j++) begin
      @(negedge clk);
      clear = 1'b0; din = 8'(j);
      #1;
      chk($sformatf("str%0d_tick", j), 32'(tick), 32'h1);
      if (j >= 2) chk($sformatf("str%0d_dout", j), 32'(dout), (j >= 7) ? 32'(j - 7) : 32'h0);
      chk($sformatf("str%0d_last", j), 32'(dout_last), (j >= 100) ? 32'(j - 100) : 32'h0);
      chk($sformatf("str%0d_primed", j), 32'(primed), (j >= 100) ? 32'h1 : 32'h0);
    end

    // Hold for 20 clocks
    for (int h = 0; h < 20; h++) begin
      @(negedge clk);
      ena = 1'b0; din = 8'hEE;
      #1;
      chk($sformatf("hold%0d_tick", h), 32'(tick), 32'h0);
      chk($sformatf("hold%0d_dout", h), 32'(dout), (h == 0) ? 32'd113 : 32'd114);
      chk($sformatf("hold%0d_last", h), 32'(dout_last), 32'd20);
      chk($sformatf("hold%0d_primed", h), 32'(primed), 32'h1);
    end

    // Resume where the stream left off
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      ena = 1'b1; din = 8'(120 + r);
      #1;
      chk($sformatf("res%0d_tick", r), 32'(tick), 32'h1);
      chk($sformatf("res%0d_dout", r), 32'(dout), (r == 0) ? 32'd114 : 32'(113 + r));
      chk($sformatf("res%0d_last", r), 32'(dout_last), 32'(20 + r));
      chk($sformatf("res%0d_primed", r), 32'(primed), 32'h1);
    end

    // Out-of-range tap, then last stage, with ena low
    @(negedge clk);
    ena = 1'b0; tap_sel = 8'd200;
    @(negedge clk);
    tap_sel = 8'd99;
    #1 chk("tap200_dout", 32'(dout), 32'h0);
    @(negedge clk);
    #1;
    chk("tap99_dout", 32'(dout), 32'd30);
    chk("tap99_last", 32'(dout_last), 32'd30);

    // Clear while cnt==0 with ena high
    @(negedge clk);
    ena = 1'b1; clear = 1'b1; tap_sel = 8'd5;
    #1;
    chk("clr_tick", 32'(tick), 32'h0);
    chk("clr_primed_before", 32'(primed), 32'h1);
    @(negedge clk);
    clear = 1'b0; din = 8'h40;
    #1;
    chk("clr_next_tick", 32'(tick), 32'h1);
    chk("clr_next_last", 32'(dout_last), 32'h0);
    chk("clr_next_primed", 32'(primed), 32'h0);
    @(negedge clk);
    din = 8'h41;
    #1 chk("clr_dout_zero", 32'(dout), 32'h0);
    for (int i = 2; i < 12; i++) begin
      @(negedge clk);
      din = 8'(8'h40 + i); tap_sel = 8'd0;
    end

    // Asynchronous reset pulse between edges
    @(negedge clk);
    #1;
    chk("pre_rst_dout", 32'(dout), 32'h4A);
    chk("pre_rst_tick", 32'(tick), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_tick", 32'(tick), 32'h0);
    chk("mid_rst_last", 32'(dout_last), 32'h0);
    chk("mid_rst_primed", 32'(primed), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_tick", 32'(tick), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
